acc_cpu_param: RTL and testbench
================================

Name: acc_cpu_param

Overview:
- Parametrised multi-cycle accumulator CPU: the next generation of the team's 16-bit single-accumulator core.
- Adds configurable data/address widths, synchronous reset, and a ready-based memory handshake (wait states).
- Adds flag computation, BRN, logic ops, HALT, and defined divide-by-zero behaviour.
- Sits between the program/data memory model and the top-level testbench/SoC wrapper.

Parameters:
- DATA_W, 16: width of AC, IR, MBR and memory data. Must be ≥ ADDR_W+5.
- ADDR_W, 11: width of PC and memory address; also the width of the IR operand field IR[ADDR_W-1:0].

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; takes priority over every other action.
- mem_rdata  in  DATA_W  memory read data; sampled only when mem_ready=1.
- mem_ready  in  1  memory completes the current mem_rd/mem_wr access this cycle.
- mem_addr  out  ADDR_W  access address.
- mem_wdata  out  DATA_W  store data; equals AC in state WRITE.
- mem_rd  out  1  read request (Moore output: 1 in FETCH and OPERAND).
- mem_wr  out  1  write request (Moore output: 1 in WRITE only).
- pc  out  ADDR_W  program counter.
- ir  out  DATA_W  instruction register.
- ac  out  DATA_W  signed accumulator.
- sr  out  4  status flags: [0] V, [1] C, [2] N, [3] Z.
- halted  out  1  high while in HALT.

Behaviour:
- Reset values: state=FETCH, pc=0, ir=0, ac=0, mbr=0, sr=0, halted=0.
  - mem_rd=1 and mem_addr=0 in the first cycle after reset.
  - Reset during any wait abandons the access.
- Instruction format:
  - IR[DATA_W-1:DATA_W-4] = opcode; IR[DATA_W-5] = mode (1 = memory operand, 0 = immediate); IR[ADDR_W-1:0] = field.
  - Immediates are zero-extended to DATA_W.
- Opcodes:
  - 0 NOP, 1 LOAD, 2 STORE, 3 ADD, 4 SUB, 5 MUL, 6 DIV, 7 BR, 8 BRZ, 9 BRN, A AND, B OR, C XOR, F HALT.
  - D and E execute as NOP.
- FETCH:
  - mem_addr=pc, mem_rd=1.
  - Stays in FETCH while mem_ready=0.
  - On mem_ready=1: ir<=mem_rdata, pc<=pc+1 (wraps mod 2^ADDR_W), go to DECODE.
- DECODE (1 cycle):
  - BR: pc<=field; next FETCH.
  - BRZ: pc<=field if sr[3]=1; next FETCH.
  - BRN: pc<=field if sr[2]=1; next FETCH.
  - Branches ignore the mode bit.
  - NOP/D/E: next FETCH.
  - HALT: next HALT.
  - STORE: next WRITE.
  - Other ops with mode=1: next OPERAND.
  - Other ops with mode=0: mbr<=imm, next EXECUTE.
- OPERAND:
  - mem_addr=field, mem_rd=1; waits on mem_ready.
  - On mem_ready=1: mbr<=mem_rdata, next EXECUTE.
- WRITE:
  - mem_addr=field, mem_wdata=ac, mem_wr=1.
  - Stores are always direct; the mode bit is ignored.
  - Waits on mem_ready, then next FETCH. AC and SR are unchanged.
- EXECUTE (1 cycle), then FETCH. Signed DATA_W arithmetic; the result r is written to ac.
  - LOAD: r=mbr; C=V=0.
  - ADD: r=ac+mbr. C = carry out of bit DATA_W-1. V = signed overflow.
  - SUB: r=ac-mbr. C = borrow (1 when ac<mbr unsigned). V = signed overflow.
  - MUL: r = low DATA_W bits of the 2·DATA_W signed product. V=1 if the product does not fit in DATA_W signed bits; C=0.
  - DIV: quotient truncated toward zero; C=0.
    - mbr=0: ac unchanged, V=1, N/Z from the unchanged ac.
    - Most-negative ÷ −1: r = most-negative, V=1.
  - AND/OR/XOR: bitwise; C=V=0.
  - All EXECUTE ops: N=r[DATA_W-1], Z=(r==0).
  - SR changes only in EXECUTE.
- HALT:
  - halted=1; mem_rd=mem_wr=0; all registers frozen.
  - Leaves HALT only on reset.
- mem_rd and mem_wr are never both 1.
- Latency with mem_ready tied to 1:
  - Immediate ALU op: 3 cycles. Memory ALU op: 4 cycles.
  - STORE: 3 cycles. Branch/NOP: 2 cycles.
  - Each extra mem_ready=0 cycle adds 1 cycle.

Test Plan:
- Reset then program {LOAD #5 (0x1005), ADD #3 (0x3003), STORE 0x040 (0x2840), HALT (0xF000)}, mem_ready=1 -> ac=8; write of 8 to address 0x040 in the STORE's WRITE cycle; sr=0000; halted=1 after 11 cycles; pc=4.
- LOAD 0x7FFF from memory, then ADD #1 -> ac=0x8000, V=1, N=1, Z=0, C=0. Then SUB #0 (0x4000) -> ac=0x8000, C=0, V=0.
- LOAD #0, BRZ 0x010 -> pc=0x010 two cycles after the BRZ fetch completes. With ac=1, BRZ not taken and pc=fetch address+1. BRN taken after SUB gives −2.
- mem_ready held 0 for 3 cycles during FETCH and during OPERAND -> mem_rd/mem_addr stable; ir/mbr unchanged until the mem_ready=1 edge; total latency +6.
- DIV #0 with ac=0x0123 -> ac=0x0123, V=1. MUL 0x0100×0x0100 -> ac=0x0000, V=1, Z=1.
- Assert reset in the middle of an OPERAND wait -> next cycle state=FETCH, pc=0, ac=0, sr=0, mem_rd=1, mem_addr=0. Instance with DATA_W=24, ADDR_W=16 runs the first program correctly.

Source files
------------

// File: rtl/acc_cpu_param.sv
// acc_cpu_param: parametrised multi-cycle single-accumulator CPU.
//
// Each instruction walks FETCH -> DECODE -> {OPERAND} -> EXECUTE, or
// FETCH -> DECODE -> WRITE for stores. Memory accesses stall on mem_ready.
// The HALT state freezes every register until reset.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   synchronous active-high reset (highest priority)
//   mem_rdata  in   memory read data, sampled when mem_ready=1
//   mem_ready  in   memory completes the current access this cycle
//   mem_addr   out  access address (pc in FETCH, operand field otherwise)
//   mem_wdata  out  store data (the accumulator)
//   mem_rd     out  read request, high in FETCH and OPERAND
//   mem_wr     out  write request, high in WRITE
//   pc         out  program counter
//   ir         out  instruction register
//   ac         out  signed accumulator
//   sr         out  flags {Z, N, C, V} in bits [3:0]
//   halted     out  high while in HALT
//
// DATA_W must be at least ADDR_W+5 so the opcode, mode bit and operand field
// fit in one instruction word without overlapping.

module acc_cpu_param #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 11
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [DATA_W-1:0]        mem_rdata,
    input  logic                     mem_ready,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    output logic                     mem_rd,
    output logic                     mem_wr,
    output logic [ADDR_W-1:0]        pc,
    output logic [DATA_W-1:0]        ir,
    output logic signed [DATA_W-1:0] ac,
    output logic [3:0]               sr,
    output logic                     halted
);

    localparam int MSB = DATA_W - 1;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_MUL   = 4'h5;
    localparam logic [3:0] OP_DIV   = 4'h6;
    localparam logic [3:0] OP_BR    = 4'h7;
    localparam logic [3:0] OP_BRZ   = 4'h8;
    localparam logic [3:0] OP_BRN   = 4'h9;
    localparam logic [3:0] OP_AND   = 4'hA;
    localparam logic [3:0] OP_OR    = 4'hB;
    localparam logic [3:0] OP_XOR   = 4'hC;
    localparam logic [3:0] OP_HALT  = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_OPERAND,
        S_EXECUTE,
        S_WRITE,
        S_HALT
    } state_t;

    state_t                     state_q, state_d;
    logic [ADDR_W-1:0]          pc_q, pc_d;
    logic [DATA_W-1:0]          ir_q, ir_d;
    logic signed [DATA_W-1:0]   ac_q, ac_d;
    logic [DATA_W-1:0]          mbr_q, mbr_d;
    logic [3:0]                 sr_q, sr_d;

    logic [3:0]                 opcode;
    logic                       mode;
    logic [ADDR_W-1:0]          field;
    logic [DATA_W+3:0]          exec_res;

    assign opcode = ir_q[DATA_W-1 -: 4];
    assign mode   = ir_q[DATA_W-5];
    assign field  = ir_q[ADDR_W-1:0];

    // Returns {Z, N, C, V, result}.
    function automatic logic [DATA_W+3:0] exec_op(
        input logic [3:0]               op,
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        logic signed [DATA_W-1:0] r;
        logic                     c;
        logic                     v;
        logic [DATA_W:0]          wide;
        logic [2*DATA_W-1:0]      prod;
        r    = a;
        c    = 1'b0;
        v    = 1'b0;
        wide = '0;
        prod = '0;
        case (op)
            OP_LOAD: r = b;
            OP_ADD: begin
                wide = {1'b0, a} + {1'b0, b};
                r    = wide[DATA_W-1:0];
                c    = wide[DATA_W];
                v    = (a[MSB] == b[MSB]) && (r[MSB] != a[MSB]);
            end
            OP_SUB: begin
                // The extra top bit of an unsigned subtract is the borrow.
                wide = {1'b0, a} - {1'b0, b};
                r    = wide[DATA_W-1:0];
                c    = wide[DATA_W];
                v    = (a[MSB] != b[MSB]) && (r[MSB] != a[MSB]);
            end
            OP_MUL: begin
                // Sign-extended operands make the truncated unsigned product
                // equal to the two's-complement product.
                prod = {{DATA_W{a[MSB]}}, a} * {{DATA_W{b[MSB]}}, b};
                r    = prod[DATA_W-1:0];
                v    = (prod != {{DATA_W{r[MSB]}}, r});
            end
            OP_DIV: begin
                if (b == '0) begin
                    r = a;
                    v = 1'b1;
                end else if ((a == {1'b1, {(DATA_W-1){1'b0}}}) && (b == '1)) begin
                    r = a;
                    v = 1'b1;
                end else begin
                    r = a / b;
                end
            end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            default: r = a;
        endcase
        return {(r == '0), r[MSB], c, v, r};
    endfunction

    assign exec_res = exec_op(opcode, ac_q, mbr_q);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        ac_d    = ac_q;
        mbr_d   = mbr_q;
        sr_d    = sr_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_BR: begin
                        pc_d    = field;
                        state_d = S_FETCH;
                    end
                    OP_BRZ: begin
                        if (sr_q[3]) pc_d = field;
                        state_d = S_FETCH;
                    end
                    OP_BRN: begin
                        if (sr_q[2]) pc_d = field;
                        state_d = S_FETCH;
                    end
                    OP_HALT:  state_d = S_HALT;
                    OP_STORE: state_d = S_WRITE;
                    OP_LOAD, OP_ADD, OP_SUB, OP_MUL, OP_DIV,
                    OP_AND, OP_OR, OP_XOR: begin
                        if (mode) begin
                            state_d = S_OPERAND;
                        end else begin
                            mbr_d   = {{(DATA_W-ADDR_W){1'b0}}, field};
                            state_d = S_EXECUTE;
                        end
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_OPERAND: begin
                if (mem_ready) begin
                    mbr_d   = mem_rdata;
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                ac_d    = exec_res[DATA_W-1:0];
                sr_d    = exec_res[DATA_W+3:DATA_W];
                state_d = S_FETCH;
            end
            S_WRITE: begin
                if (mem_ready) state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            ac_q    <= '0;
            mbr_q   <= '0;
            sr_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            ac_q    <= ac_d;
            mbr_q   <= mbr_d;
            sr_q    <= sr_d;
        end
    end

    assign mem_addr  = (state_q == S_FETCH) ? pc_q : field;
    assign mem_wdata = ac_q;
    assign mem_rd    = (state_q == S_FETCH) || (state_q == S_OPERAND);
    assign mem_wr    = (state_q == S_WRITE);
    assign pc        = pc_q;
    assign ir        = ir_q;
    assign ac        = ac_q;
    assign sr        = sr_q;
    assign halted    = (state_q == S_HALT);

endmodule

// File: tb/tb_acc_cpu_param.sv
module tb_acc_cpu_param;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // Instance A: default 16/11 configuration.
    logic         reset_a, ready_a;
    logic [15:0]  rdata_a, wdata_a, ir_a, ac_a;
    logic [10:0]  addr_a, pc_a;
    logic         rd_a, wr_a, halted_a;
    logic [3:0]   sr_a;
    logic [15:0]  mem_a [0:2047];

    // Instance B: 24/16 configuration.
    logic         reset_b;
    logic         ready_b = 1'b1;
    logic [23:0]  rdata_b, wdata_b, ir_b, ac_b;
    logic [15:0]  addr_b, pc_b;
    logic         rd_b, wr_b, halted_b;
    logic [3:0]   sr_b;
    logic [23:0]  mem_b [0:65535];

    acc_cpu_param dut_a (
        .clock(clock), .reset(reset_a), .mem_rdata(rdata_a), .mem_ready(ready_a),
        .mem_addr(addr_a), .mem_wdata(wdata_a), .mem_rd(rd_a), .mem_wr(wr_a),
        .pc(pc_a), .ir(ir_a), .ac(ac_a), .sr(sr_a), .halted(halted_a)
    );

    acc_cpu_param #(.DATA_W(24), .ADDR_W(16)) dut_b (
        .clock(clock), .reset(reset_b), .mem_rdata(rdata_b), .mem_ready(ready_b),
        .mem_addr(addr_b), .mem_wdata(wdata_b), .mem_rd(rd_b), .mem_wr(wr_b),
        .pc(pc_b), .ir(ir_b), .ac(ac_b), .sr(sr_b), .halted(halted_b)
    );

    assign rdata_a = mem_a[addr_a];
    assign rdata_b = mem_b[addr_b];

    always @(posedge clock) begin
        if (wr_a && ready_a) mem_a[addr_a] = wdata_a;
        if (wr_b && ready_b) mem_b[addr_b] = wdata_b;
    end

    int n_total = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Write scoreboard: expected stores are queued with the program and
    // popped when the DUT performs a completed write.
    typedef struct {
        logic [15:0] addr;
        logic [23:0] data;
    } wr_t;
    wr_t wq_a[$];
    wr_t wq_b[$];

    always @(negedge clock) begin
        wr_t e;
        if (wr_a && ready_a) begin
            if (wq_a.size() == 0) chk("a_unexpected_write", {21'd0, addr_a}, 32'hFFFF_FFFF);
            else begin
                e = wq_a.pop_front();
                chk("a_wr_addr", {21'd0, addr_a}, {16'd0, e.addr});
                chk("a_wr_data", {16'd0, wdata_a}, {8'd0, e.data});
            end
        end
        if (wr_b && ready_b) begin
            if (wq_b.size() == 0) chk("b_unexpected_write", {16'd0, addr_b}, 32'hFFFF_FFFF);
            else begin
                e = wq_b.pop_front();
                chk("b_wr_addr", {16'd0, addr_b}, {16'd0, e.addr});
                chk("b_wr_data", {8'd0, wdata_b}, {8'd0, e.data});
            end
        end
    end

    task automatic reset_a_pulse();
        reset_a = 1'b1;
        cyc(1);
        reset_a = 1'b0;
    endtask

    initial begin
        reset_a = 1'b1;
        reset_b = 1'b1;
        ready_a = 1'b1;
        cyc(1);

        // ---- Program 1: LOAD #5, ADD #3, STORE 0x040, HALT ----
        mem_a[0] = 16'h1005; mem_a[1] = 16'h3003; mem_a[2] = 16'h2840; mem_a[3] = 16'hF000;
        wq_a.push_back('{addr: 16'h0040, data: 24'h000008});
        reset_a = 1'b1;
        cyc(1);
        chk("rst_pc", pc_a, 0);
        chk("rst_ir", ir_a, 0);
        chk("rst_ac", ac_a, 0);
        chk("rst_sr", sr_a, 0);
        chk("rst_halted", halted_a, 0);
        chk("rst_mem_rd", rd_a, 1);
        chk("rst_mem_wr", wr_a, 0);
        chk("rst_mem_addr", addr_a, 0);
        reset_a = 1'b0;
        cyc(10);
        chk("p1_not_halted_at_10", halted_a, 0);
        cyc(1);
        chk("p1_halted", halted_a, 1);
        chk("p1_ac", ac_a, 16'h0008);
        chk("p1_sr", sr_a, 4'h0);
        chk("p1_pc", pc_a, 4);
        chk("p1_halt_rd", rd_a, 0);
        cyc(3);
        chk("p1_frozen_pc", pc_a, 4);
        chk("p1_frozen_ac", ac_a, 16'h0008);
        chk("p1_frozen_halted", halted_a, 1);
        chk("p1_mem_040", mem_a[11'h040], 16'h0008);

        // ---- Program 2: overflow into sign bit, then SUB #0 ----
        mem_a[0] = 16'h1900; mem_a[1] = 16'h3001; mem_a[2] = 16'h4000; mem_a[3] = 16'hF000;
        mem_a[11'h100] = 16'h7FFF;
        reset_a_pulse();
        cyc(4);
        chk("p2_load_mem", ac_a, 16'h7FFF);
        chk("p2_load_sr", sr_a, 4'h0);
        cyc(3);
        chk("p2_add_ac", ac_a, 16'h8000);
        chk("p2_add_sr", sr_a, 4'b0101);
        cyc(3);
        chk("p2_sub_ac", ac_a, 16'h8000);
        chk("p2_sub_sr", sr_a, 4'b0100);

        // ---- Program 3: branches ----
        mem_a[0] = 16'h1000; mem_a[1] = 16'h8010;
        mem_a[11'h010] = 16'h1001; mem_a[11'h011] = 16'h8020; mem_a[11'h012] = 16'h4003;
        mem_a[11'h013] = 16'h9030; mem_a[11'h030] = 16'hF000;
        reset_a_pulse();
        cyc(3);
        chk("p3_load0_sr", sr_a, 4'b1000);
        cyc(1);
        chk("p3_brz_fetch_pc", pc_a, 2);
        cyc(1);
        chk("p3_brz_taken_pc", pc_a, 11'h010);
        cyc(3);
        chk("p3_load1_ac", ac_a, 16'h0001);
        cyc(2);
        chk("p3_brz_not_taken_pc", pc_a, 11'h012);
        cyc(3);
        chk("p3_sub_ac", ac_a, 16'hFFFE);
        chk("p3_sub_sr", sr_a, 4'b0110);
        cyc(2);
        chk("p3_brn_taken_pc", pc_a, 11'h030);
        cyc(2);
        chk("p3_halted", halted_a, 1);

        // ---- Program 4: wait states in FETCH and OPERAND ----
        mem_a[0] = 16'h3900; mem_a[1] = 16'hF000; mem_a[11'h100] = 16'h0011;
        reset_a = 1'b1;
        cyc(1);
        reset_a = 1'b0;
        ready_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk("p4_fetch_wait_rd", rd_a, 1);
            chk("p4_fetch_wait_addr", addr_a, 0);
            chk("p4_fetch_wait_ir", ir_a, 0);
        end
        ready_a = 1'b1;
        cyc(1);
        chk("p4_fetch_ir", ir_a, 16'h3900);
        chk("p4_fetch_pc", pc_a, 1);
        ready_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            chk("p4_opnd_wait_rd", rd_a, 1);
            chk("p4_opnd_wait_addr", addr_a, 11'h100);
            chk("p4_opnd_wait_ac", ac_a, 0);
        end
        ready_a = 1'b1;
        cyc(1);
        chk("p4_exec_rd", rd_a, 0);
        chk("p4_exec_ac_old", ac_a, 0);
        cyc(1);
        chk("p4_total_latency_ac", ac_a, 16'h0011);

        // ---- Program 5: DIV/MUL corner cases, logic ops, carry ----
        mem_a[0]  = 16'h1123; mem_a[1]  = 16'h6000; mem_a[2]  = 16'h1100; mem_a[3]  = 16'h5100;
        mem_a[4]  = 16'h1A00; mem_a[5]  = 16'h6A01; mem_a[6]  = 16'h1A02; mem_a[7]  = 16'h6002;
        mem_a[8]  = 16'h10F0; mem_a[9]  = 16'hC0FF; mem_a[10] = 16'hB300; mem_a[11] = 16'hA10C;
        mem_a[12] = 16'h1A03; mem_a[13] = 16'h3001; mem_a[14] = 16'hF000;
        mem_a[11'h200] = 16'h8000; mem_a[11'h201] = 16'hFFFF;
        mem_a[11'h202] = 16'hFFF9; mem_a[11'h203] = 16'hFFFF;
        reset_a_pulse();
        cyc(3);
        chk("p5_load_ac", ac_a, 16'h0123);
        cyc(3);
        chk("p5_div0_ac", ac_a, 16'h0123);
        chk("p5_div0_sr", sr_a, 4'b0001);
        cyc(6);
        chk("p5_mul_ac", ac_a, 16'h0000);
        chk("p5_mul_sr", sr_a, 4'b1001);
        cyc(8);
        chk("p5_divmin_ac", ac_a, 16'h8000);
        chk("p5_divmin_sr", sr_a, 4'b0101);
        cyc(7);
        chk("p5_divneg_ac", ac_a, 16'hFFFD);
        chk("p5_divneg_sr", sr_a, 4'b0100);
        cyc(6);
        chk("p5_xor_ac", ac_a, 16'h000F);
        cyc(3);
        chk("p5_or_ac", ac_a, 16'h030F);
        cyc(3);
        chk("p5_and_ac", ac_a, 16'h010C);
        chk("p5_and_sr", sr_a, 4'b0000);
        cyc(7);
        chk("p5_carry_ac", ac_a, 16'h0000);
        chk("p5_carry_sr", sr_a, 4'b1010);

        // ---- Program 6: reset during an OPERAND wait ----
        mem_a[0] = 16'h1005; mem_a[1] = 16'h3900; mem_a[2] = 16'hF000;
        reset_a_pulse();
        cyc(4);
        chk("p6_pre_ac", ac_a, 16'h0005);
        ready_a = 1'b0;
        cyc(2);
        chk("p6_wait_rd", rd_a, 1);
        chk("p6_wait_addr", addr_a, 11'h100);
        reset_a = 1'b1;
        cyc(1);
        reset_a = 1'b0;
        ready_a = 1'b1;
        chk("p6_rst_pc", pc_a, 0);
        chk("p6_rst_ac", ac_a, 0);
        chk("p6_rst_sr", sr_a, 0);
        chk("p6_rst_rd", rd_a, 1);
        chk("p6_rst_addr", addr_a, 0);
        reset_a = 1'b1;

        // ---- Instance B (24/16): program 1 ----
        mem_b[0] = 24'h100005; mem_b[1] = 24'h300003; mem_b[2] = 24'h280040; mem_b[3] = 24'hF00000;
        wq_b.push_back('{addr: 16'h0040, data: 24'h000008});
        reset_b = 1'b1;
        cyc(1);
        chk("b_rst_rd", rd_b, 1);
        chk("b_rst_pc", pc_b, 0);
        reset_b = 1'b0;
        cyc(11);
        chk("b_halted", halted_b, 1);
        chk("b_ac", ac_b, 24'h000008);
        chk("b_sr", sr_b, 4'h0);
        chk("b_pc", pc_b, 4);
        chk("b_mem_040", mem_b[16'h0040], 24'h000008);

        chk("a_writes_drained", wq_a.size(), 0);
        chk("b_writes_drained", wq_b.size(), 0);

        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end

endmodule
